jt6295_rom_sched: RTL
=====================

// Module: jt6295_rom_sched
// PURPOSE
//  Shares the single ADPCM ROM port between the phrase-table reader (10-bit header address) and
//  four voice sample fetchers (18-bit address each). Fixed priority to the header reader, then
//  round-robin among voices. Each requester gets a one-byte cache so repeat reads cost no ROM cycle.
//  Sits between the control/voice blocks and the top-level ROM (SDRAM) interface.
// PARAMETERS
//  TOUT    255  ROM wait limit in clk cycles (used only with JT6295_ROM_TOUT_EN), 8-bit range
// PORTS
//  clk         in   1   system clock; only clock
//  rst         in   1   synchronous, active-high reset
//  hdr_addr    in   10  phrase-table byte address; ROM address = {8'd0, hdr_addr}
//  hdr_cs      in   1   header read request, level
//  hdr_data    out  8   header byte
//  hdr_ok      out  1   hdr_data valid for the current hdr_addr
//  ch_addr     in   72  voice addresses, ch n at [18n+17:18n]
//  ch_cs       in   4   voice read requests, level
//  ch_data     out  32  voice bytes, ch n at [8n+7:8n]
//  ch_ok       out  4   ch_data[n] valid for the current ch_addr[n]
//  rom_addr    out  18  ROM byte address
//  rom_cs      out  1   ROM request
//  rom_data    in   8   ROM data
//  rom_ok      in   1   ROM data valid for rom_addr
//  rom_err     out  1   sticky timeout flag (0 when JT6295_ROM_TOUT_EN is undefined)
// BEHAVIOUR
//  Reset: rom_cs=0, rom_addr=0, all *_ok=0, all *_data=0, caches invalid, rr pointer=ch0,
//   rom_err=0, FSM=IDLE. Reset mid-transfer abandons it; rom_cs is 0 on the cycle after reset.
//  Requester rule: ok is high only while cs=1 and the cached address equals the input address.
//   Address change or cs=0 -> ok low in the same cycle (combinational compare on registered cache).
//  Cache hit (cs=1, address match, cache valid): ok=1 in the same cycle; no ROM access.
//  Miss -> pending. FSM states:
//   IDLE : choose the header if pending, else the next pending voice after the last one granted
//          (rr order 0-1-2-3-0). Latch the requester id and address, drive rom_addr, set rom_cs=1 -> WAIT.
//   WAIT : the first cycle after issue ignores rom_ok (SDRAM ok lags the address change).
//          After that, rom_ok=1 -> write rom_data into the owner cache, mark it valid with the
//          latched address, rom_cs=0 -> IDLE.
//  Miss-to-ok latency: 3 clk plus ROM wait (grant, issue, capture). A freed slot is re-granted
//   the cycle after capture.
//  Requester drops cs or changes address during WAIT: the transfer still completes and fills the
//   cache with the latched address. ok then follows the compare rule (a stale fill gives no false ok).
//  Header and voice pending together: the header wins; the voice rr pointer does not advance.
//  All four voices pending: each is served once before any voice is served again.
//  Same address requested by two voices: each cache fills separately (no cross-sharing).
// CONFIGURATION
//  JT6295_ROM_TOUT_EN defined: a cycle counter in WAIT. If it reaches TOUT without rom_ok,
//   store 8'h00 as the owner's data (valid, so the voice decodes silence), set rom_err (cleared
//   only by rst), rom_cs=0 -> IDLE.
//  JT6295_ROM_TOUT_EN undefined: no counter, WAIT lasts until rom_ok, rom_err tied to 0.
// STRUCTURE
//  jt6295_pkg holds: requester ids (REQ_HDR=4, REQ_CH0..3=0..3), FSM state encodings (IDLE, WAIT),
//   ROM address width constant 18.
//  Sub-module jt6295_rr_arb: 4-way round-robin picker (req[3:0], advance, gnt one-hot, last-grant
//   pointer). The top level adds the header override and the FSM.
// TESTING
//  1 hdr_cs=1 addr=10'h008, ROM returns 8'h3C after 4 clk -> hdr_ok rises with hdr_data=3C;
//    same addr again -> hdr_ok with no rom_cs pulse.
//  2 ch_cs=4'hF, all misses, ROM ok at 2 clk -> grant order 0,1,2,3 then rr continues;
//    hdr_cs raised mid-run -> served next, rr order kept.
//  3 ch1 address changes 18'h00100 -> 18'h00101 during WAIT -> ch_ok[1] stays 0 after the stale
//    fill; a new fetch of 00101 then gives ok.
//  4 rom_ok held at 1 permanently -> the ok in the first WAIT cycle is ignored; the capture
//    happens on the second cycle.
//  5 rst pulsed during WAIT -> next cycle rom_cs=0, all ok=0, ch0 is granted first afterwards.
//  6 (JT6295_ROM_TOUT_EN, TOUT=8) rom_ok never set -> after 8 clk ch_data=00, ok=1, rom_err=1
//    until rst.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 ROM scheduler: requester ids, FSM encoding,
// ROM address width and a one-hot decode helper.
`timescale 1ns/1ps
package jt6295_pkg;

    localparam int ROM_AW = 18;
    localparam int NUM_CH = 4;
    localparam int NUM_REQ = NUM_CH + 1;

    typedef logic [2:0] req_id_t;

    localparam req_id_t REQ_CH0 = 3'd0;
    localparam req_id_t REQ_CH1 = 3'd1;
    localparam req_id_t REQ_CH2 = 3'd2;
    localparam req_id_t REQ_CH3 = 3'd3;
    localparam req_id_t REQ_HDR = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } sched_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/jt6295_rr_arb.sv
// Four-way round-robin picker. The pointer names the channel with the highest
// priority on the next pick; it moves past the winner only when advance is set.
`timescale 1ns/1ps
module jt6295_rr_arb
    import jt6295_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_advance,
    output logic [3:0] o_gnt
);

    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic [3:0] w_gnt;

    // Scan from furthest to nearest so the channel closest to the pointer wins.
    always_comb begin
        w_gnt = 4'b0000;
        w_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + k[1:0];
            if (i_req[w_idx]) begin
                w_gnt = 4'b0001 << w_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 2'd0;
        end else if (i_advance && (|w_gnt)) begin
            r_ptr <= onehot_to_idx(w_gnt) + 2'd1;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/jt6295_rom_sched.sv
// Shares one ADPCM ROM port between the phrase-table reader and four voices,
// with a one-byte cache per requester. Optional ROM timeout: JT6295_ROM_TOUT_EN.
`timescale 1ns/1ps
module jt6295_rom_sched
    import jt6295_pkg::*;
#(
    parameter int unsigned TOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_hdr_addr,
    input  logic              i_hdr_cs,
    output logic [7:0]        o_hdr_data,
    output logic              o_hdr_ok,
    input  logic [71:0]       i_ch_addr,
    input  logic [3:0]        i_ch_cs,
    output logic [31:0]       o_ch_data,
    output logic [3:0]        o_ch_ok,
    output logic [ROM_AW-1:0] o_rom_addr,
    output logic              o_rom_cs,
    input  logic [7:0]        i_rom_data,
    input  logic              i_rom_ok,
    output logic              o_rom_err
);

    logic [ROM_AW-1:0] w_reqAddr [NUM_REQ];
    logic [NUM_REQ-1:0] w_reqCs;
    logic [NUM_REQ-1:0] w_hit;
    logic [NUM_REQ-1:0] w_pend;

    logic [ROM_AW-1:0] r_cacheAddr [NUM_REQ];
    logic [7:0]        r_cacheData [NUM_REQ];
    logic [NUM_REQ-1:0] r_cacheValid;

    sched_state_t      r_state;
    sched_state_t      w_nextState;
    logic              r_romCs;
    logic              r_first;
    logic [ROM_AW-1:0] r_romAddr;
    req_id_t           r_owner;
    req_id_t           w_nextOwner;
    logic              w_grant;
    logic              w_advance;
    logic              w_fill;
    logic [7:0]        w_fillData;
    logic [3:0]        w_chGnt;

`ifdef JT6295_ROM_TOUT_EN
    logic [7:0]        r_waitCnt;
    logic              r_romErr;
    logic              w_timeout;
`endif

    // Index 4 is the header reader; its 10-bit address sits in the low bits of the ROM space.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_reqAddr[n] = i_ch_addr[18*n +: 18];
            w_reqCs[n]   = i_ch_cs[n];
        end
        w_reqAddr[REQ_HDR] = {8'd0, i_hdr_addr};
        w_reqCs[REQ_HDR]   = i_hdr_cs;
        for (int n = 0; n < NUM_REQ; n++) begin
            w_hit[n] = w_reqCs[n] && r_cacheValid[n] && (r_cacheAddr[n] == w_reqAddr[n]);
        end
        w_pend = w_reqCs & ~w_hit;
    end

    jt6295_rr_arb u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (w_pend[3:0]),
        .i_advance (w_advance),
        .o_gnt     (w_chGnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The first WAIT cycle ignores rom_ok because the SDRAM ok lags the address change.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_advance   = 1'b0;
        w_nextOwner = REQ_HDR;
        w_fill      = 1'b0;
        w_fillData  = i_rom_data;
`ifdef JT6295_ROM_TOUT_EN
        w_timeout   = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_pend[REQ_HDR]) begin
                    w_grant     = 1'b1;
                    w_nextOwner = REQ_HDR;
                    w_nextState = ST_WAIT;
                end else if (|w_pend[3:0]) begin
                    w_grant     = 1'b1;
                    w_advance   = 1'b1;
                    w_nextOwner = {1'b0, onehot_to_idx(w_chGnt)};
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!r_first && i_rom_ok) begin
                    w_fill      = 1'b1;
                    w_nextState = ST_IDLE;
                end
`ifdef JT6295_ROM_TOUT_EN
                else if (r_waitCnt == (TOUT[7:0] - 8'd1)) begin
                    w_fill      = 1'b1;
                    w_fillData  = 8'h00;
                    w_timeout   = 1'b1;
                    w_nextState = ST_IDLE;
                end
`endif
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // The fill always uses the latched address, so a requester that moved on sees a miss.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_romCs      <= 1'b0;
            r_romAddr    <= '0;
            r_owner      <= REQ_CH0;
            r_first      <= 1'b0;
            r_cacheValid <= '0;
            for (int n = 0; n < NUM_REQ; n++) begin
                r_cacheAddr[n] <= '0;
                r_cacheData[n] <= 8'h00;
            end
        end else begin
            if (w_grant) begin
                r_owner   <= w_nextOwner;
                r_romAddr <= w_reqAddr[w_nextOwner];
                r_romCs   <= 1'b1;
                r_first   <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_first <= 1'b0;
            end
            if (w_fill) begin
                r_cacheData[r_owner]  <= w_fillData;
                r_cacheAddr[r_owner]  <= r_romAddr;
                r_cacheValid[r_owner] <= 1'b1;
                r_romCs               <= 1'b0;
            end
        end
    end

`ifdef JT6295_ROM_TOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_waitCnt <= 8'd0;
            r_romErr  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_waitCnt <= 8'd0;
            end else if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
            if (w_timeout) begin
                r_romErr <= 1'b1;
            end
        end
    end

    assign o_rom_err = r_romErr;
`else
    assign o_rom_err = 1'b0;
`endif

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            o_ch_data[8*n +: 8] = r_cacheData[n];
        end
    end

    assign o_ch_ok    = w_hit[3:0];
    assign o_hdr_ok   = w_hit[REQ_HDR];
    assign o_hdr_data = r_cacheData[REQ_HDR];
    assign o_rom_addr = r_romAddr;
    assign o_rom_cs   = r_romCs;

endmodule
